// File: rtl/dsm_pkg.sv
// Shared definitions for the delta-sigma modulator/demodulator path:
// bit-level mapping, CIC gain arithmetic and a generic signed saturator.
package dsm_pkg;

    localparam int PCM_ONE  = 1;
    localparam int PCM_ZERO = -1;

    // Bit growth of an ORDER-stage CIC with ratio DECIM and comb delay DIFF_DELAY.
    function automatic int cic_gain_bits(input int order, input int decim, input int diff_delay);
        return order * $clog2(decim * diff_delay);
    endfunction

    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] x, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb section, y = x - x[n-DELAY], advancing only on the strobe
// that accompanies each decimated sample.
module cic_comb_stage
    import dsm_pkg::*;
#(
    parameter int W     = 20,
    parameter int DELAY = 1
) (
    input  logic                clk,
    input  logic                arst_n,
    input  logic                in_stb,
    input  logic signed [W-1:0] in_data,
    output logic                out_stb,
    output logic signed [W-1:0] out_data
);

    logic signed [W-1:0] dly_q [DELAY];
    logic signed [W-1:0] dly_d [DELAY];
    logic signed [W-1:0] y_q;
    logic signed [W-1:0] y_d;
    logic                stb_q;
    logic                stb_d;

    always_comb begin
        stb_d = in_stb;
        y_d   = y_q;
        for (int k = 0; k < DELAY; k++) begin
            dly_d[k] = dly_q[k];
        end
        if (in_stb) begin
            // Modulo-2^W difference; wrap in the integrators cancels here.
            y_d      = in_data - dly_q[DELAY-1];
            dly_d[0] = in_data;
            for (int k = 1; k < DELAY; k++) begin
                dly_d[k] = dly_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            stb_q <= 1'b0;
            y_q   <= '0;
            for (int k = 0; k < DELAY; k++) begin
                dly_q[k] <= '0;
            end
        end else begin
            stb_q <= stb_d;
            y_q   <= y_d;
            for (int k = 0; k < DELAY; k++) begin
                dly_q[k] <= dly_d[k];
            end
        end
    end

    assign out_stb  = stb_q;
    assign out_data = y_q;

endmodule

// File: rtl/axis_cic_decim.sv
// Decimating CIC filter: 1-bit delta-sigma stream in on AXI-Stream,
// signed WIDTH-bit PCM out at fs/DECIM. Fully pipelined, never stalls.
module axis_cic_decim
    import dsm_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int ORDER      = 3,
    parameter int DECIM      = 64,
    parameter int DIFF_DELAY = 1
) (
    input  logic             aclk,
    input  logic             arst_n,
    input  logic             s_axis_data_tdata,
    input  logic             s_axis_data_tvalid,
    output logic             s_axis_data_tready,
    output logic [WIDTH-1:0] m_axis_data_tdata,
    output logic             m_axis_data_tvalid
);

    localparam int G   = cic_gain_bits(ORDER, DECIM, DIFF_DELAY);
    localparam int IW  = G + 2;
    localparam int SH  = G - (WIDTH - 1);
    localparam int CW  = $clog2(DECIM);
    localparam int WU  = ORDER * DIFF_DELAY;
    localparam int WCW = $clog2(WU + 1);

    if (G < WIDTH - 1) begin : g_chk_gain
        $error("axis_cic_decim: gain bits G=%0d below WIDTH-1=%0d", G, WIDTH - 1);
    end
    if (ORDER < 1 || ORDER > 6) begin : g_chk_order
        $error("axis_cic_decim: ORDER=%0d outside 1..6", ORDER);
    end
    if (DECIM < 2 || (DECIM & (DECIM - 1)) != 0) begin : g_chk_decim
        $error("axis_cic_decim: DECIM=%0d must be a power of two >= 2", DECIM);
    end
    if (DIFF_DELAY != 1 && DIFF_DELAY != 2) begin : g_chk_delay
        $error("axis_cic_decim: DIFF_DELAY=%0d must be 1 or 2", DIFF_DELAY);
    end

    logic                 tready_q, tready_d;
    logic                 accept;
    logic signed [IW-1:0] in_pm1;

    logic signed [IW-1:0] integ_q [ORDER];
    logic signed [IW-1:0] integ_d [ORDER];
    logic [ORDER-1:0]     ivld_q, ivld_d;

    logic [CW-1:0]        dcnt_q, dcnt_d;
    logic signed [IW-1:0] samp_q, samp_d;
    logic                 dstb_q, dstb_d;

    logic signed [IW-1:0] comb_x [ORDER+1];
    logic [ORDER:0]       comb_stb;

    logic [WCW-1:0]       wcnt_q, wcnt_d;
    logic [WIDTH-1:0]     tdata_q, tdata_d;
    logic                 tvalid_q, tvalid_d;
    logic signed [IW-1:0] shifted;
    logic signed [63:0]   wide;

    assign accept = s_axis_data_tvalid && tready_q;
    assign in_pm1 = s_axis_data_tdata ? IW'(PCM_ONE) : IW'(PCM_ZERO);

    always_comb begin
        tready_d = 1'b1;

        ivld_d[0]  = accept;
        integ_d[0] = accept ? integ_q[0] + in_pm1 : integ_q[0];
        for (int k = 1; k < ORDER; k++) begin
            ivld_d[k]  = ivld_q[k-1];
            integ_d[k] = ivld_q[k-1] ? integ_q[k] + integ_q[k-1] : integ_q[k];
        end

        dcnt_d = dcnt_q;
        samp_d = samp_q;
        dstb_d = 1'b0;
        if (ivld_q[ORDER-1]) begin
            if (dcnt_q == CW'(DECIM - 1)) begin
                dcnt_d = '0;
                samp_d = integ_q[ORDER-1];
                dstb_d = 1'b1;
            end else begin
                dcnt_d = dcnt_q + CW'(1);
            end
        end
    end

    assign comb_x[0]   = samp_q;
    assign comb_stb[0] = dstb_q;

    for (genvar k = 0; k < ORDER; k++) begin : g_comb
        cic_comb_stage #(
            .W     (IW),
            .DELAY (DIFF_DELAY)
        ) u_comb (
            .clk      (aclk),
            .arst_n   (arst_n),
            .in_stb   (comb_stb[k]),
            .in_data  (comb_x[k]),
            .out_stb  (comb_stb[k+1]),
            .out_data (comb_x[k+1])
        );
    end

    // Output stage: scale to WIDTH, clip +full scale, gate by warm-up.
    always_comb begin
        shifted  = comb_x[ORDER] >>> SH;
        wide     = {{(64 - IW){shifted[IW-1]}}, shifted};
        tdata_d  = tdata_q;
        tvalid_d = 1'b0;
        wcnt_d   = wcnt_q;
        if (comb_stb[ORDER]) begin
            tdata_d  = WIDTH'(sat_signed(wide, WIDTH));
            tvalid_d = (wcnt_q == WCW'(WU));
            if (wcnt_q != WCW'(WU)) begin
                wcnt_d = wcnt_q + WCW'(1);
            end
        end
    end

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            tready_q <= 1'b0;
            ivld_q   <= '0;
            for (int k = 0; k < ORDER; k++) begin
                integ_q[k] <= '0;
            end
            dcnt_q   <= '0;
            samp_q   <= '0;
            dstb_q   <= 1'b0;
            wcnt_q   <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
        end else begin
            tready_q <= tready_d;
            ivld_q   <= ivld_d;
            for (int k = 0; k < ORDER; k++) begin
                integ_q[k] <= integ_d[k];
            end
            dcnt_q   <= dcnt_d;
            samp_q   <= samp_d;
            dstb_q   <= dstb_d;
            wcnt_q   <= wcnt_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
        end
    end

    assign s_axis_data_tready = tready_q;
    assign m_axis_data_tdata  = tdata_q;
    assign m_axis_data_tvalid = tvalid_q;

endmodule

// File: tb/tb_axis_cic_decim.sv
// Directed bench for axis_cic_decim at default parameters (ORDER=3,
// DECIM=64, M=1, WIDTH=16): steady-state values, pulse timing and reset.
module tb_axis_cic_decim;

    localparam int WIDTH = 16;
    localparam int DECIM = 64;
    localparam int LAT   = 7;
    localparam int WARM  = 3;

    logic             aclk = 1'b0;
    logic             arst_n = 1'b0;
    logic             s_tdata = 1'b0;
    logic             s_tvalid = 1'b0;
    logic             s_tready;
    logic [WIDTH-1:0] m_tdata;
    logic             m_tvalid;

    int ncmp = 0;
    int nfail = 0;
    int ecnt = 0;
    int nacc = 0;
    int nframe = 0;
    int outs_seen = 0;
    int exp_data = 0;
    int pend[$];

    always #5 aclk = ~aclk;

    axis_cic_decim #(
        .WIDTH      (WIDTH),
        .ORDER      (3),
        .DECIM      (DECIM),
        .DIFF_DELAY (1)
    ) dut (
        .aclk               (aclk),
        .arst_n             (arst_n),
        .s_axis_data_tdata  (s_tdata),
        .s_axis_data_tvalid (s_tvalid),
        .s_axis_data_tready (s_tready),
        .m_axis_data_tdata  (m_tdata),
        .m_axis_data_tvalid (m_tvalid)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        ncmp++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, expv, ecnt);
        end
    endtask

    // Advance one edge, then check the output pulse against the expected schedule.
    task automatic tick();
        bit exp_v;
        @(posedge aclk);
        ecnt++;
        #1;
        exp_v = (pend.size() > 0) && (pend[0] == ecnt);
        if (exp_v) void'(pend.pop_front());
        chk("m_tvalid", {31'b0, m_tvalid}, {31'b0, exp_v});
        if (exp_v && m_tvalid === 1'b1) begin
            chk("m_tdata", $signed(m_tdata), exp_data);
            outs_seen++;
        end
    endtask

    task automatic do_reset(input int ncyc);
        arst_n   = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = 1'b0;
        nacc     = 0;
        nframe   = 0;
        pend.delete();
        #1;
        chk("rst_async_tready", {31'b0, s_tready}, 0);
        chk("rst_async_tdata", $signed(m_tdata), 0);
        chk("rst_async_tvalid", {31'b0, m_tvalid}, 0);
        repeat (ncyc) begin
            tick();
            chk("rst_tready", {31'b0, s_tready}, 0);
            chk("rst_tdata", $signed(m_tdata), 0);
        end
        arst_n = 1'b1;
        #1;
        chk("rel_tready_before_edge", {31'b0, s_tready}, 0);
        tick();
        chk("rel_tready_after_edge", {31'b0, s_tready}, 1);
    endtask

    task automatic run(input logic [3:0] pat, input int plen, input int nbits, input bit toggle,
                       input int expv, input int flush, input int nout);
        int got;
        int cyc;
        bit acc;
        got       = 0;
        cyc       = 0;
        exp_data  = expv;
        outs_seen = 0;
        s_tvalid  = 1'b0;
        while (got < nbits && cyc < 4 * nbits + 20) begin
            s_tvalid = toggle ? ~s_tvalid : 1'b1;
            s_tdata  = pat[nacc % plen];
            acc      = s_tvalid && s_tready;
            tick();
            cyc++;
            if (acc) begin
                got++;
                nacc++;
                if (nacc % DECIM == 0) begin
                    nframe++;
                    if (nframe > WARM) pend.push_back(ecnt + LAT);
                end
            end
        end
        chk("accepted_bits", got, nbits);
        s_tvalid = 1'b0;
        repeat (flush) tick();
        chk("output_count", outs_seen, nout);
    endtask

    initial begin
        // All ones: +full scale clips to 32767.
        do_reset(3);
        run(4'b0001, 1, 6 * DECIM, 1'b0, 32767, 12, 3);

        // All zeros: -full scale is exactly representable.
        do_reset(2);
        run(4'b0000, 1, 6 * DECIM, 1'b0, -32768, 12, 3);

        // 1,0,1,0: CIC null at fs/2.
        do_reset(2);
        run(4'b0101, 4, 6 * DECIM, 1'b0, 0, 12, 3);

        // 1,1,1,0: mean +0.5, integrators wrap.
        do_reset(2);
        run(4'b0111, 4, 6 * DECIM, 1'b0, 16384, 12, 3);

        // Same pattern with tvalid toggling every cycle.
        do_reset(2);
        run(4'b0111, 4, 6 * DECIM, 1'b1, 16384, 12, 3);

        // Reset mid-frame after 100 bits; warm-up restarts.
        do_reset(2);
        run(4'b0111, 4, 100, 1'b0, 0, 0, 0);
        do_reset(3);
        run(4'b0001, 1, 4 * DECIM, 1'b0, 32767, 12, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
